z3_autoconfig: RTL
==================

Name: z3_autoconfig

Overview:
- Zorro III AUTOCONFIG responder and board-space decoder for the A4092; sits directly upstream of the ROM access stage.
- Synchronises FCS_n and latches the cycle address and direction.
- Serves the config nibbles before configuration and accepts the base-address and shut-up writes.
- After configuration, produces the qualified slave_cycle, READ, configured and shutup signals that downstream stages consume.

Parameters:
- ER_TYPE, 8'h80, er_Type byte (Zorro III, board-size code).
- PRODUCT, 8'h54, product number.
- ER_FLAGS, 8'h30, er_Flags byte (Z3 size extension).
- MANUFACTURER, 16'h0202, manufacturer ID.
- SERIAL, 32'h00000000, serial number.
- ROM_VECTOR, 16'h0000, diag ROM vector offset.

Ports:
- CLK, in, 1, system clock.
- RESET_n, in, 1, asynchronous active-low reset.
- FCS_n, in, 1, Zorro III full cycle strobe (asynchronous to CLK).
- ADDR, in, 32, Zorro III address; stable while FCS_n low.
- READ_in, in, 1, bus direction (1 = read).
- CFGIN_n, in, 1, autoconfig chain input.
- DIN, in, 4, data bus D[31:28] for config writes.
- CFGOUT_n, out, 1, autoconfig chain output.
- slave_cycle, out, 1, cycle targets this board's 256MB space.
- READ, out, 1, latched direction for the current cycle.
- OFFSET, out, 28, latched ADDR[27:0] for downstream decoders.
- configured, out, 1, base address has been assigned.
- shutup, out, 1, board was told to shut up.
- cfg_data, out, 4, config nibble for D[31:28].
- cfg_oe, out, 1, drive cfg_data onto the bus.
- cfg_dtack, out, 1, config-space cycle acknowledge.

Behaviour:
- Clock and reset: one clock (CLK). RESET_n is asynchronous, active-low.
- Reset values: configured=0, shutup=0, CFGOUT_n=1, slave_cycle=0, READ=1, OFFSET=0, cfg_data=4'hF, cfg_oe=0, cfg_dtack=0, base register=4'h0, FSM=IDLE.
- FCS_n synchroniser: 2-flop, reset to 1. fcs_s is the synchronised value.
- Cycle start: on the CLK where fcs_s goes 1→0, latch ADDR[31:0] and READ_in. READ and OFFSET update that same edge and hold until the next cycle start.
- Config space hit: fcs_s low && !configured && !shutup && !CFGIN_n && latched ADDR[31:16]==16'hFF00.
- Board hit: fcs_s low && configured && !shutup && latched ADDR[31:28]==base. slave_cycle is registered and asserts the CLK after latch, 2 CLKs after FCS_n falls at minimum. It deasserts the CLK after fcs_s returns high.
- Config register addressing: register index r = ADDR[7:2]; nibble select = ADDR[8] (0 = high nibble, 1 = low nibble).
- Register map:
  - r=0x00: ER_TYPE.
  - r=0x01: PRODUCT.
  - r=0x02: ER_FLAGS.
  - r=0x04/0x05: MANUFACTURER[15:8]/[7:0].
  - r=0x06..0x09: SERIAL bytes, MSB first.
  - r=0x0A/0x0B: ROM_VECTOR[15:8]/[7:0].
  - Others: 8'h00.
- Inversion: every register except r=0x00 is returned inverted.
- FSM states: IDLE, DECODE, ACK, WAIT_END.
  - IDLE → DECODE on the cycle-start edge.
  - DECODE: on config hit → ACK; else → WAIT_END (no acknowledge; downstream stages own board cycles).
  - ACK: cfg_dtack=1. For reads, cfg_oe=1 and cfg_data=selected nibble. For writes, the action below executes once, on ACK entry. Then → WAIT_END.
  - WAIT_END: hold cfg_dtack/cfg_oe as set in ACK. On fcs_s high → IDLE, clearing cfg_dtack, cfg_oe and cfg_data=4'hF.
- Config writes:
  - r=0x11 (offset 0x44): base←DIN, configured←1, CFGOUT_n←0.
  - r=0x13 (offset 0x4C): shutup←1, CFGOUT_n←0.
  - Other write offsets: acknowledged, no effect.
- Writes while configured or shutup are not config hits; the state is sticky until reset.
- Reads of offset 0x44/0x4C return the ROM map values (i.e. 4'hF).
- FCS_n rising during DECODE: go to IDLE without acknowledging.
- Reset mid-cycle: all outputs return to reset values immediately. A cycle in flight is dropped; the next FCS_n fall starts fresh.
- CFGIN_n high: no config response at all, and CFGOUT_n stays 1.

Decomposition:
- Shared package z3_pkg holds:
  - FSM state typedef.
  - Config register index constants (REG_TYPE=0x00, REG_BASE=0x11, REG_SHUTUP=0x13, ...).
  - Config space prefix 16'hFF00.
  - Board size constant (ADDR[31:28] compare).
- One sub-module: z3_cfg_rom. Pure combinational index/nibble → nibble lookup with inversion, parameterised by the ID parameters.
- The top level holds the synchroniser, latch, FSM and config registers.

Test Plan:
- Reset then CFGIN_n=0, read ADDR=32'hFF000000 → cfg_dtack within 4 CLKs of FCS_n fall, cfg_oe=1, cfg_data=4'h8 (ER_TYPE hi, not inverted).
- Read ADDR=32'hFF000104 (PRODUCT lo nibble) → cfg_data=4'hB (~4'h4). Read FF000010 → cfg_data=4'hF (~MANUFACTURER hi nibble 0).
- Write DIN=4'h4 to 32'hFF000044 → configured=1, CFGOUT_n=0. Then read 32'h40000000 → slave_cycle=1, OFFSET=0, READ=1, no cfg_dtack. Read 32'h50000000 → slave_cycle=0.
- Write to FF00004C before configuration → shutup=1, CFGOUT_n=0, configured=0. Subsequent FF000000 reads get no cfg_dtack.
- CFGIN_n=1, read FF000000 → no cfg_dtack, cfg_oe=0, CFGOUT_n=1.
- Assert RESET_n low mid-ACK of a config read → cfg_dtack/cfg_oe drop asynchronously and configured=0. After release, a fresh cycle behaves as after power-up.

Source files
------------

// File: rtl/z3_pkg.sv
// z3_pkg: shared types and constants for the Zorro III autoconfig responder.
package z3_pkg;
  typedef enum logic [1:0] {IDLE, DECODE, ACK, WAIT_END} z3_state_e;
  localparam logic [5:0] REG_TYPE    = 6'h00;
  localparam logic [5:0] REG_PRODUCT = 6'h01;
  localparam logic [5:0] REG_FLAGS   = 6'h02;
  localparam logic [5:0] REG_MFG_HI  = 6'h04;
  localparam logic [5:0] REG_MFG_LO  = 6'h05;
  localparam logic [5:0] REG_SER_3   = 6'h06;
  localparam logic [5:0] REG_SER_2   = 6'h07;
  localparam logic [5:0] REG_SER_1   = 6'h08;
  localparam logic [5:0] REG_SER_0   = 6'h09;
  localparam logic [5:0] REG_ROMV_HI = 6'h0A;
  localparam logic [5:0] REG_ROMV_LO = 6'h0B;
  localparam logic [5:0] REG_BASE    = 6'h11;
  localparam logic [5:0] REG_SHUTUP  = 6'h13;
  localparam logic [15:0] CFG_PREFIX = 16'hFF00;
  // 256MB board: only ADDR[31:28] is compared against the assigned base
  localparam int BOARD_BITS = 4;
endpackage

// File: rtl/z3_cfg_rom.sv
// z3_cfg_rom: config register index/nibble to bus nibble, all but er_Type inverted.
module z3_cfg_rom
  import z3_pkg::*;
#(
  parameter logic [7:0]  ER_TYPE      = 8'h80,
  parameter logic [7:0]  PRODUCT      = 8'h54,
  parameter logic [7:0]  ER_FLAGS     = 8'h30,
  parameter logic [15:0] MANUFACTURER = 16'h0202,
  parameter logic [31:0] SERIAL       = 32'h00000000,
  parameter logic [15:0] ROM_VECTOR   = 16'h0000
) (
  input  logic [5:0] idx_i,
  input  logic       nib_sel_i,
  output logic [3:0] nib_o
);
  logic [7:0] raw, val;
  always_comb begin
    raw = 8'h00;
    case (idx_i)
      REG_TYPE:    raw = ER_TYPE;
      REG_PRODUCT: raw = PRODUCT;
      REG_FLAGS:   raw = ER_FLAGS;
      REG_MFG_HI:  raw = MANUFACTURER[15:8];
      REG_MFG_LO:  raw = MANUFACTURER[7:0];
      REG_SER_3:   raw = SERIAL[31:24];
      REG_SER_2:   raw = SERIAL[23:16];
      REG_SER_1:   raw = SERIAL[15:8];
      REG_SER_0:   raw = SERIAL[7:0];
      REG_ROMV_HI: raw = ROM_VECTOR[15:8];
      REG_ROMV_LO: raw = ROM_VECTOR[7:0];
      default:     raw = 8'h00;
    endcase
  end
  assign val   = (idx_i == REG_TYPE) ? raw : ~raw;
  assign nib_o = nib_sel_i ? val[3:0] : val[7:4];
endmodule

// File: rtl/z3_autoconfig.sv
// z3_autoconfig: Zorro III AUTOCONFIG responder and board-space decoder.
module z3_autoconfig
  import z3_pkg::*;
#(
  parameter logic [7:0]  ER_TYPE      = 8'h80,
  parameter logic [7:0]  PRODUCT      = 8'h54,
  parameter logic [7:0]  ER_FLAGS     = 8'h30,
  parameter logic [15:0] MANUFACTURER = 16'h0202,
  parameter logic [31:0] SERIAL       = 32'h00000000,
  parameter logic [15:0] ROM_VECTOR   = 16'h0000
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic        FCS_n,
  input  logic [31:0] ADDR,
  input  logic        READ_in,
  input  logic        CFGIN_n,
  input  logic [3:0]  DIN,
  output logic        CFGOUT_n,
  output logic        slave_cycle,
  output logic        READ,
  output logic [27:0] OFFSET,
  output logic        configured,
  output logic        shutup,
  output logic [3:0]  cfg_data,
  output logic        cfg_oe,
  output logic        cfg_dtack
);
  z3_state_e   state_q, state_d;
  logic        fcs_m_q, fcs_s_q;
  logic [31:0] addr_q;
  logic        read_q;
  logic [3:0]  base_q, base_d, data_q, data_d;
  logic        conf_q, conf_d, shut_q, shut_d, cfgout_n_q, cfgout_n_d;
  logic        slave_q, slave_d, dtack_q, dtack_d, oe_q, oe_d;
  logic        fcs_fall, cfg_hit, board_hit;
  logic [5:0]  reg_idx;
  logic [3:0]  rom_nib;

  assign fcs_fall  = fcs_s_q & ~fcs_m_q;
  assign reg_idx   = addr_q[7:2];
  assign cfg_hit   = ~fcs_s_q & ~conf_q & ~shut_q & ~CFGIN_n & (addr_q[31:16] == CFG_PREFIX);
  assign board_hit = ~fcs_s_q & conf_q & ~shut_q & (addr_q[31 -: BOARD_BITS] == base_q);

  z3_cfg_rom #(
    .ER_TYPE(ER_TYPE), .PRODUCT(PRODUCT), .ER_FLAGS(ER_FLAGS),
    .MANUFACTURER(MANUFACTURER), .SERIAL(SERIAL), .ROM_VECTOR(ROM_VECTOR)
  ) u_rom (
    .idx_i(reg_idx),
    .nib_sel_i(addr_q[8]),
    .nib_o(rom_nib)
  );

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      fcs_m_q    <= 1'b1;
      fcs_s_q    <= 1'b1;
      addr_q     <= '0;
      read_q     <= 1'b1;
      state_q    <= IDLE;
      base_q     <= 4'h0;
      conf_q     <= 1'b0;
      shut_q     <= 1'b0;
      cfgout_n_q <= 1'b1;
      slave_q    <= 1'b0;
      dtack_q    <= 1'b0;
      oe_q       <= 1'b0;
      data_q     <= 4'hF;
    end else begin
      fcs_m_q    <= FCS_n;
      fcs_s_q    <= fcs_m_q;
      addr_q     <= fcs_fall ? ADDR : addr_q;
      read_q     <= fcs_fall ? READ_in : read_q;
      state_q    <= state_d;
      base_q     <= base_d;
      conf_q     <= conf_d;
      shut_q     <= shut_d;
      cfgout_n_q <= cfgout_n_d;
      slave_q    <= slave_d;
      dtack_q    <= dtack_d;
      oe_q       <= oe_d;
      data_q     <= data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    conf_d     = conf_q;
    shut_d     = shut_q;
    cfgout_n_d = cfgout_n_q;
    slave_d    = board_hit;
    dtack_d    = dtack_q;
    oe_d       = oe_q;
    data_d     = data_q;
    case (state_q)
      IDLE: state_d = fcs_fall ? DECODE : IDLE;
      DECODE: begin
        if (fcs_s_q) begin
          state_d = IDLE;
        end else if (cfg_hit) begin
          // Outputs and write side effects take effect on ACK entry
          state_d = ACK;
          dtack_d = 1'b1;
          oe_d    = read_q;
          data_d  = read_q ? rom_nib : 4'hF;
          if (!read_q && reg_idx == REG_BASE) begin
            base_d     = DIN;
            conf_d     = 1'b1;
            cfgout_n_d = 1'b0;
          end
          if (!read_q && reg_idx == REG_SHUTUP) begin
            shut_d     = 1'b1;
            cfgout_n_d = 1'b0;
          end
        end else begin
          state_d = WAIT_END;
        end
      end
      ACK: state_d = WAIT_END;
      WAIT_END: begin
        if (fcs_s_q) begin
          // A new strobe can already be falling on the same edge
          state_d = fcs_fall ? DECODE : IDLE;
          dtack_d = 1'b0;
          oe_d    = 1'b0;
          data_d  = 4'hF;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign CFGOUT_n    = cfgout_n_q;
  assign slave_cycle = slave_q;
  assign READ        = read_q;
  assign OFFSET      = addr_q[27:0];
  assign configured  = conf_q;
  assign shutup      = shut_q;
  assign cfg_data    = data_q;
  assign cfg_oe      = oe_q;
  assign cfg_dtack   = dtack_q;
endmodule
